// File: rtl/credit_flit_injector_if.sv
// Source-side and router-side flit handshake bundle for credit_flit_injector.
// slave = injector view, master = producer/router (bench) view.
interface credit_flit_injector_if #(
   parameter int N_SRC     = 2,
   parameter int FLIT_SIZE = 32
);
   logic [N_SRC-1:0]           src_valid_i;
   logic [N_SRC-1:0]           src_last_i;
   logic [N_SRC*FLIT_SIZE-1:0] src_data_i;
   logic [N_SRC-1:0]           src_ready_o;
   logic                       tx_o;
   logic                       credit_i;
   logic [FLIT_SIZE-1:0]       data_o;

   modport slave (
      input  src_valid_i, src_last_i, src_data_i, credit_i,
      output src_ready_o, tx_o, data_o
   );

   modport master (
      output src_valid_i, src_last_i, src_data_i, credit_i,
      input  src_ready_o, tx_o, data_o
   );
endinterface

// File: rtl/credit_flit_injector.sv
// Multi-source flit injector: per-source FIFOs, packet-granular round-robin onto a
// credit-based router port. Define INJECTOR_STALL_WATCHDOG_EN to build the credit-stall watchdog.
module credit_flit_injector #(
   parameter int FLIT_SIZE   = 32,
   parameter int N_SRC       = 2,
   parameter int FIFO_DEPTH  = 8,
   parameter int STALL_LIMIT = 1024,
   localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   credit_flit_injector_if.slave bus,
   output logic [GW-1:0]         grant_o,
   output logic                  busy_o,
   output logic [31:0]           flits_sent_o,
   output logic                  stall_o
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q, state_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [GW-1:0]      rr_q, rr_d;
   logic [31:0]        flits_q, flits_d;
   logic [FLIT_SIZE:0] mem_q    [N_SRC][FIFO_DEPTH];
   logic [FLIT_SIZE:0] mem_d    [N_SRC][FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_q [N_SRC];
   logic [AW-1:0]      wr_ptr_d [N_SRC];
   logic [AW-1:0]      rd_ptr_q [N_SRC];
   logic [AW-1:0]      rd_ptr_d [N_SRC];
   logic [CNTW-1:0]    count_q  [N_SRC];
   logic [CNTW-1:0]    count_d  [N_SRC];

   logic [N_SRC-1:0]   full, empty, push, pop;
   logic [FLIT_SIZE:0] head;
   logic               tx, xfer, found;
   logic [GW-1:0]      pick, cand;

   // A full FIFO refuses writes even when it is being popped the same cycle.
   always_comb begin
      for (int k = 0; k < N_SRC; k++) begin
         full[k]  = (count_q[k] == CNTW'(FIFO_DEPTH));
         empty[k] = (count_q[k] == '0);
         push[k]  = bus.src_valid_i[k] && !full[k];
      end
   end

   assign head = mem_q[grant_q][rd_ptr_q[grant_q]];
   assign tx   = (state_q == SEND) && !empty[grant_q];
   assign xfer = tx && bus.credit_i;

   always_comb begin
      mem_d = mem_q;
      for (int k = 0; k < N_SRC; k++) begin
         pop[k]      = xfer && (grant_q == GW'(k));
         wr_ptr_d[k] = wr_ptr_q[k];
         rd_ptr_d[k] = rd_ptr_q[k];
         count_d[k]  = count_q[k] + CNTW'(push[k]) - CNTW'(pop[k]);
         if (push[k]) begin
            mem_d[k][wr_ptr_q[k]] = {bus.src_last_i[k], bus.src_data_i[k*FLIT_SIZE +: FLIT_SIZE]};
            wr_ptr_d[k]           = wr_ptr_q[k] + AW'(1);
         end
         if (pop[k]) begin
            rd_ptr_d[k] = rd_ptr_q[k] + AW'(1);
         end
      end
   end

   // The grant is held for a whole packet; a drained FIFO mid-packet just idles tx.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      flits_d = flits_q;
      found   = 1'b0;
      pick    = grant_q;
      cand    = '0;
      case (state_q)
         IDLE: begin
            for (int i = 1; i <= N_SRC; i++) begin
               cand = GW'((int'(rr_q) + i) % N_SRC);
               if (!found && !empty[cand]) begin
                  found = 1'b1;
                  pick  = cand;
               end
            end
            if (found) begin
               grant_d = pick;
               state_d = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               flits_d = flits_q + 32'd1;
               if (head[FLIT_SIZE]) begin
                  rr_d    = grant_q;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= GW'(N_SRC - 1);
         flits_q <= '0;
         for (int k = 0; k < N_SRC; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            count_q[k]  <= '0;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
               mem_q[k][e] <= '0;
            end
         end
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_q     <= rr_d;
         flits_q  <= flits_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef INJECTOR_STALL_WATCHDOG_EN
   localparam int SW = $clog2(STALL_LIMIT + 1);

   logic [SW-1:0] stall_cnt_q, stall_cnt_d;
   logic          stall_q, stall_d;

   // Counts consecutive credit-starved cycles, saturating; the flag is sticky.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (xfer) begin
         stall_cnt_d = '0;
      end else if (tx && !bus.credit_i && (stall_cnt_q != SW'(STALL_LIMIT))) begin
         stall_cnt_d = stall_cnt_q + SW'(1);
      end
      stall_d = stall_q || (stall_cnt_d == SW'(STALL_LIMIT));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         stall_q     <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         stall_q     <= stall_d;
      end
   end

   assign stall_o = stall_q;
`else
   // The limit only matters when the watchdog is built in.
   assign stall_o = 1'b0 & (STALL_LIMIT != 0);
`endif

   assign bus.src_ready_o = ~full;
   assign bus.tx_o        = tx;
   assign bus.data_o      = head[FLIT_SIZE-1:0];
   assign grant_o         = grant_q;
   assign busy_o          = (state_q == SEND);
   assign flits_sent_o    = flits_q;
endmodule

// File: tb/tb_credit_flit_injector.sv
// Directed, scoreboard-checked bench for credit_flit_injector (N_SRC=2, depth 8, stall limit 16).
module tb_credit_flit_injector;
   localparam int FS = 32;
   localparam int NS = 2;

   typedef struct {
      logic [0:0]  grant;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:0]  grant;
   logic        busy;
   logic [31:0] flits;
   logic        stall;
   exp_t        sb[$];
   exp_t        e;
   int          checks   = 0;
   int          errors   = 0;
   int          expFlits = 0;
   logic        expStall;

   credit_flit_injector_if #(.N_SRC(NS), .FLIT_SIZE(FS)) bus ();

   credit_flit_injector #(
      .FLIT_SIZE(FS), .N_SRC(NS), .FIFO_DEPTH(8), .STALL_LIMIT(16)
   ) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus),
      .grant_o(grant), .busy_o(busy), .flits_sent_o(flits), .stall_o(stall)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expectFlit(input int src, input logic [31:0] d);
      exp_t x;
      x.grant = 1'(src);
      x.data  = d;
      sb.push_back(x);
   endtask

   task automatic applyStimulus(input int src, input logic v, input logic l, input logic [31:0] d);
      bus.src_valid_i[src]        = v;
      bus.src_last_i[src]         = l;
      bus.src_data_i[src*FS +: FS] = d;
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 100) begin
         tick();
         n++;
      end
      checkOutput({tag, "_idle"}, 32'(n < 100), 32'd1);
      checkOutput({tag, "_flits"}, flits, 32'(expFlits));
   endtask

   // Scoreboard: every transfer must match the next expected flit and owner
   always @(negedge clk) begin
      if (!rst && bus.tx_o && bus.credit_i) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_xfer_sb_size", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            checkOutput("xfer_data", bus.data_o, e.data);
            checkOutput("xfer_grant", 32'(grant), 32'(e.grant));
            expFlits++;
         end
      end
   end

   initial begin
`ifdef INJECTOR_STALL_WATCHDOG_EN
      expStall = 1'b1;
`else
      expStall = 1'b0;
`endif
      rst             = 1'b1;
      bus.src_valid_i = '0;
      bus.src_last_i  = '0;
      bus.src_data_i  = '0;
      bus.credit_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.credit_i = 1'b1;
      tick();
      checkOutput("rst_tx", 32'(bus.tx_o), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_grant", 32'(grant), 0);
      checkOutput("rst_flits", flits, 0);
      checkOutput("rst_stall", 32'(stall), 0);
      checkOutput("rst_ready", 32'(bus.src_ready_o), 32'h3);

      $display("[TB] simultaneous two-source packets");
      expectFlit(0, 32'hB0); expectFlit(0, 32'hB1);
      expectFlit(1, 32'hC0); expectFlit(1, 32'hC1);
      applyStimulus(0, 1, 0, 32'hB0); applyStimulus(1, 1, 0, 32'hC0);
      tick();
      checkOutput("t2_tx_lat1", 32'(bus.tx_o), 0);
      applyStimulus(0, 1, 1, 32'hB1); applyStimulus(1, 1, 1, 32'hC1);
      tick();
      checkOutput("t2_tx_lat2", 32'(bus.tx_o), 1);
      checkOutput("t2_grant0", 32'(grant), 0);
      applyStimulus(0, 0, 0, 0); applyStimulus(1, 0, 0, 0);
      tick(); tick();
      checkOutput("t2_gap_busy", 32'(busy), 0);
      checkOutput("t2_gap_tx", 32'(bus.tx_o), 0);
      tick();
      checkOutput("t2_grant1", 32'(grant), 1);
      checkOutput("t2_data_c0", bus.data_o, 32'hC0);
      tick(); tick();
      checkOutput("t2_done_busy", 32'(busy), 0);
      checkOutput("t2_flits", flits, 4);
      waitIdle("t2");

      $display("[TB] single source 4-flit packet");
      for (int i = 0; i < 4; i++) expectFlit(0, 32'hA0 + 32'(i));
      applyStimulus(0, 1, 0, 32'hA0);
      tick();
      checkOutput("t1_tx_lat1", 32'(bus.tx_o), 0);
      applyStimulus(0, 1, 0, 32'hA1);
      tick();
      checkOutput("t1_tx_lat2", 32'(bus.tx_o), 1);
      checkOutput("t1_busy", 32'(busy), 1);
      checkOutput("t1_data_a0", bus.data_o, 32'hA0);
      applyStimulus(0, 1, 0, 32'hA2);
      tick();
      applyStimulus(0, 1, 1, 32'hA3);
      tick();
      applyStimulus(0, 0, 0, 0);
      tick(); tick();
      checkOutput("t1_busy_fall", 32'(busy), 0);
      checkOutput("t1_flits", flits, 8);
      waitIdle("t1");

      $display("[TB] FIFO fill with credit withheld");
      bus.credit_i = 1'b0;
      for (int i = 0; i < 8; i++) expectFlit(0, 32'hD0 + 32'(i));
      expectFlit(0, 32'hD8);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1, 0, 32'hD0 + 32'(i));
         tick();
      end
      checkOutput("t3_full_ready", 32'(bus.src_ready_o), 32'h2);
      applyStimulus(0, 1, 0, 32'hEE);
      tick();
      checkOutput("t3_still_full", 32'(bus.src_ready_o), 32'h2);
      checkOutput("t3_tx_nocredit", 32'(bus.tx_o), 1);
      checkOutput("t3_no_xfer", flits, 32'(expFlits));
      bus.credit_i = 1'b1;
      tick();
      checkOutput("t3_no_bypass", 32'(bus.src_ready_o), 32'h3);
      applyStimulus(0, 0, 0, 0);
      repeat (7) tick();
      checkOutput("t3_drained_tx", 32'(bus.tx_o), 0);
      checkOutput("t3_drained_busy", 32'(busy), 1);
      checkOutput("t3_drained_flits", flits, 32'(expFlits));
      applyStimulus(0, 1, 1, 32'hD8);
      tick();
      applyStimulus(0, 0, 0, 0);
      waitIdle("t3");

      $display("[TB] mid-packet starvation holds the grant");
      expectFlit(0, 32'hE0); expectFlit(0, 32'hE1); expectFlit(0, 32'hE2);
      expectFlit(1, 32'hF0); expectFlit(1, 32'hF1);
      applyStimulus(0, 1, 0, 32'hE0);
      tick();
      applyStimulus(0, 0, 0, 0);
      tick();
      checkOutput("t4_grant0", 32'(grant), 0);
      applyStimulus(1, 1, 0, 32'hF0);
      tick();
      applyStimulus(1, 1, 1, 32'hF1);
      tick();
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("t4_pause_tx", 32'(bus.tx_o), 0);
         checkOutput("t4_pause_grant", 32'(grant), 0);
         tick();
      end
      applyStimulus(0, 1, 0, 32'hE1);
      tick();
      applyStimulus(0, 1, 1, 32'hE2);
      tick();
      applyStimulus(0, 0, 0, 0);
      waitIdle("t4");

      $display("[TB] reset mid-packet");
      expectFlit(0, 32'h60); expectFlit(0, 32'h61);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, (i == 3), 32'h60 + 32'(i));
         tick();
      end
      applyStimulus(0, 0, 0, 0);
      rst = 1'b1;
      #1;
      checkOutput("t5_tx", 32'(bus.tx_o), 0);
      checkOutput("t5_flits", flits, 0);
      checkOutput("t5_ready", 32'(bus.src_ready_o), 32'h3);
      checkOutput("t5_busy", 32'(busy), 0);
      checkOutput("t5_sb_empty", 32'(sb.size()), 0);
      expFlits = 0;
      #10;
      rst = 1'b0;
      tick();
      expectFlit(0, 32'h70);
      applyStimulus(0, 1, 1, 32'h70);
      tick();
      applyStimulus(0, 0, 0, 0);
      waitIdle("t5");

      $display("[TB] credit stall watchdog");
      bus.credit_i = 1'b0;
      expectFlit(0, 32'h80);
      applyStimulus(0, 1, 1, 32'h80);
      tick();
      applyStimulus(0, 0, 0, 0);
      tick();
      repeat (15) tick();
      checkOutput("wd_15_stall", 32'(stall), 0);
      bus.credit_i = 1'b1;
      tick();
      checkOutput("wd_15_after", 32'(stall), 0);
      waitIdle("wd_a");
      bus.credit_i = 1'b0;
      expectFlit(0, 32'h81);
      applyStimulus(0, 1, 1, 32'h81);
      tick();
      applyStimulus(0, 0, 0, 0);
      tick();
      repeat (16) tick();
      checkOutput("wd_16_stall", 32'(stall), 32'(expStall));
      bus.credit_i = 1'b1;
      tick();
      checkOutput("wd_16_sticky", 32'(stall), 32'(expStall));
      waitIdle("wd_b");
      checkOutput("wd_final", 32'(stall), 32'(expStall));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
